// File: rtl/sccb_target_regfile_if.sv
// Bus and register-file signals of the SCCB target.
// master = bus/regfile side, slave = the target itself.
interface sccb_target_regfile_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;

   modport master (
      output scl_in, sda_in, rd_data,
      input  sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
   );

   modport slave (
      input  scl_in, sda_in, rd_data,
      output sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
   );
endinterface

// File: rtl/sccb_target_regfile.sv
// SCCB/I2C target decoding device/sub-address writes and reads
// against an external 8-bit register file.
module sccb_target_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h21,
   parameter bit         AUTO_INC = 1'b1
) (
   input logic                  clk,
   input logic                  reset,
   sccb_target_regfile_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE,
      DEVADDR,
      SUBADDR,
      WDATA,
      RDATA,
      MACK,
      IGNORE,
      ACK_WAIT,
      ACK_END
   } state_t;

   state_t     state;
   state_t     ret_state;
   logic       scl_s1, scl_s2, scl_d;
   logic       sda_s1, sda_s2, sda_d;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic       sda_oe_q;
   logic       wr_en_q;
   logic [7:0] wr_addr_q;
   logic [7:0] wr_data_q;
   logic [7:0] rd_addr_q;
   logic       busy_q;

   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic [7:0] rx_byte;

   always_comb begin
      scl_rise  = scl_s2 & ~scl_d;
      scl_fall  = ~scl_s2 & scl_d;
      start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
      stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
      rx_byte   = {shreg[6:0], sda_s2};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_s1    <= 1'b1;
         scl_s2    <= 1'b1;
         scl_d     <= 1'b1;
         sda_s1    <= 1'b1;
         sda_s2    <= 1'b1;
         sda_d     <= 1'b1;
         state     <= IDLE;
         ret_state <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         sda_oe_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         scl_s1  <= bus.scl_in;
         scl_s2  <= scl_s1;
         scl_d   <= scl_s2;
         sda_s1  <= bus.sda_in;
         sda_s2  <= sda_s1;
         sda_d   <= sda_s2;
         wr_en_q <= 1'b0;

         // Increment one cycle after the strobe so wr_addr and rd_addr agree during it
         if (wr_en_q && AUTO_INC)
            rd_addr_q <= rd_addr_q + 8'd1;

         if (stop_det) begin
            state    <= IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            bit_cnt  <= '0;
         end else if (start_det) begin
            state    <= DEVADDR;
            sda_oe_q <= 1'b0;
            bit_cnt  <= '0;
         end else begin
            case (state)
               DEVADDR, SUBADDR, WDATA: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state <= ACK_WAIT;
                        if (state == DEVADDR) begin
                           if (rx_byte[7:1] == DEV_ADDR) begin
                              busy_q    <= 1'b1;
                              ret_state <= rx_byte[0] ? RDATA : SUBADDR;
                           end else begin
                              state <= IGNORE;
                           end
                        end else if (state == SUBADDR) begin
                           rd_addr_q <= rx_byte;
                           ret_state <= WDATA;
                        end else begin
                           wr_en_q   <= 1'b1;
                           wr_addr_q <= rd_addr_q;
                           wr_data_q <= rx_byte;
                           ret_state <= WDATA;
                        end
                     end
                  end
               end

               ACK_WAIT: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b1;
                     state    <= ACK_END;
                  end
               end

               // Also entered after a master ACK, with sda_oe already released
               ACK_END: begin
                  if (scl_fall) begin
                     bit_cnt <= '0;
                     state   <= ret_state;
                     if (ret_state == RDATA) begin
                        shreg    <= bus.rd_data;
                        sda_oe_q <= ~bus.rd_data[7];
                     end else begin
                        sda_oe_q <= 1'b0;
                     end
                  end
               end

               RDATA: begin
                  if (scl_fall) begin
                     if (bit_cnt == 3'd7) begin
                        sda_oe_q <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= MACK;
                     end else begin
                        shreg    <= {shreg[6:0], 1'b0};
                        sda_oe_q <= ~shreg[6];
                        bit_cnt  <= bit_cnt + 3'd1;
                     end
                  end
               end

               MACK: begin
                  if (scl_rise) begin
                     if (!sda_s2) begin
                        if (AUTO_INC)
                           rd_addr_q <= rd_addr_q + 8'd1;
                        ret_state <= RDATA;
                        state     <= ACK_END;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end

               default: ;
            endcase
         end
      end
   end

   assign bus.sda_oe  = sda_oe_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_sccb_target_regfile.sv
// Bench for sccb_target_regfile: bit-banged SCCB master, register file,
// and a transaction-level model of expected writes, ACKs and read data.
module tb_sccb_target_regfile;

   localparam int unsigned Q = 5;

   logic clk = 1'b0;
   logic reset;
   logic m_scl;
   logic m_sda;

   always #5 clk = ~clk;

   sccb_target_regfile_if bus ();

   sccb_target_regfile #(
      .DEV_ADDR (7'h21),
      .AUTO_INC (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.scl_in = m_scl;
   assign bus.sda_in = m_sda & ~bus.sda_oe;

   function automatic logic [7:0] init_val(input int unsigned a);
      if (a == 32'h3A) return 8'h04;
      return 8'((a * 73 + 19) & 32'hFF);
   endfunction

   logic [7:0] regfile [256];
   assign bus.rd_data = regfile[bus.rd_addr];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) regfile[i] <= init_val(i);
      end else if (bus.wr_en) begin
         regfile[bus.wr_addr] <= bus.wr_data;
      end
   end

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   int unsigned rise_cyc = 0;
   logic        rst_q    = 1'b1;
   logic        scl_q    = 1'b1;
   logic        mon_en   = 1'b0;
   logic        oe_prev  = 1'b0;
   logic        wr_en_prev = 1'b0;
   int          wr_count = 0;
   logic [7:0]  last_wr_addr = '0;
   logic [7:0]  last_wr_data = '0;

   // Model state
   logic [7:0]  mdl_mem [256];
   logic [7:0]  exp_rd;
   logic [15:0] wr_q [$];
   logic [7:0]  dbuf [8];
   logic [7:0]  first_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
      scl_q <= m_scl;
   end

   always @(negedge clk) begin
      logic [15:0] pair;
      if (mon_en) begin
         if (bus.wr_en === 1'b1) begin
            wr_count++;
            last_wr_addr = bus.wr_addr;
            last_wr_data = bus.wr_data;
            check("wr_en_width", wr_en_prev, 1'b0);
            check("wr_en_latency", cyc - rise_cyc, 3);
            if (wr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL wr_en_unexpected: got addr %0h data %0h required no strobe",
                        bus.wr_addr, bus.wr_data);
            end else begin
               pair = wr_q.pop_front();
               check("wr_addr", bus.wr_addr, pair[15:8]);
               check("wr_data", bus.wr_data, pair[7:0]);
            end
         end
         if (bus.sda_oe !== oe_prev && !rst_q)
            check("sda_oe_change_scl_low", scl_q, 1'b0);
      end
      oe_prev    = bus.sda_oe;
      wr_en_prev = bus.wr_en;
   end

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
      exp_rd = '0;
      wr_q.delete();
   endtask

   task automatic bus_start();
      m_sda = 1'b1; wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      m_sda = 1'b0; wait_clk(Q);
      m_scl = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      m_sda = 1'b1; wait_clk(Q);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;    wait_clk(Q);
      m_scl = 1'b1; rise_cyc = cyc; wait_clk(2 * Q);
      m_scl = 1'b0; wait_clk(Q);
   endtask

   task automatic recv_bit(output logic b);
      m_sda = 1'b1; wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      b = bus.sda_in; wait_clk(Q);
      m_scl = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack_n);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      recv_bit(ack_n);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(nack);
   endtask

   task automatic finish_txn();
      bus_stop();
      wait_clk(4);
      check("busy_after_stop", bus.busy, 1'b0);
      check("rd_addr", bus.rd_addr, exp_rd);
      check("wr_q_drained", wr_q.size(), 0);
   endtask

   task automatic txn_write(input logic [7:0] sub, input int unsigned n);
      logic a;
      bus_start();
      write_byte(8'h42, a); check("ack_dev_w", a, 1'b0);
      check("busy_active", bus.busy, 1'b1);
      write_byte(sub, a);   check("ack_sub", a, 1'b0);
      exp_rd = sub;
      for (int unsigned i = 0; i < n; i++) begin
         wr_q.push_back({exp_rd, dbuf[i]});
         mdl_mem[exp_rd] = dbuf[i];
         write_byte(dbuf[i], a); check("ack_data", a, 1'b0);
         exp_rd++;
      end
      finish_txn();
   endtask

   task automatic txn_read(input bit set_sub, input logic [7:0] sub, input int unsigned n);
      logic       a;
      logic [7:0] d;
      bus_start();
      if (set_sub) begin
         write_byte(8'h42, a); check("ack_dev_w", a, 1'b0);
         write_byte(sub, a);   check("ack_sub", a, 1'b0);
         exp_rd = sub;
         bus_start();
      end
      write_byte(8'h43, a); check("ack_dev_r", a, 1'b0);
      check("busy_active", bus.busy, 1'b1);
      for (int unsigned i = 0; i < n; i++) begin
         read_byte(d, i == n - 1);
         check("rd_byte", d, mdl_mem[exp_rd]);
         if (i == 0) first_rd = d;
         if (i != n - 1) exp_rd++;
      end
      finish_txn();
   endtask

   task automatic txn_foreign(input logic [7:0] addr_byte, input int unsigned n);
      logic a;
      bus_start();
      write_byte(addr_byte, a); check("nack_foreign", a, 1'b1);
      check("busy_foreign", bus.busy, 1'b0);
      for (int unsigned i = 0; i < n; i++) begin
         write_byte(8'($urandom), a); check("nack_foreign_data", a, 1'b1);
      end
      finish_txn();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic                a;
      logic [7:0]          sub;
      logic [6:0]          fa;
      int unsigned         kind;
      int unsigned         n;

      m_scl = 1'b1;
      m_sda = 1'b1;
      reset = 1'b1;
      model_reset();
      wait_clk(5);
      reset = 1'b0;
      wait_clk(2);
      mon_en = 1'b1;

      check("rst_sda_oe",  bus.sda_oe,  1'b0);
      check("rst_wr_en",   bus.wr_en,   1'b0);
      check("rst_wr_addr", bus.wr_addr, 8'h00);
      check("rst_wr_data", bus.wr_data, 8'h00);
      check("rst_rd_addr", bus.rd_addr, 8'h00);
      check("rst_busy",    bus.busy,    1'b0);

      // 42/0C/55
      dbuf[0] = 8'h55;
      txn_write(8'h0C, 1);
      check("t1_wr_count", wr_count, 1);
      check("t1_wr_addr", last_wr_addr, 8'h0C);
      check("t1_wr_data", last_wr_data, 8'h55);

      // 42/FF/AA/BB with wrap
      dbuf[0] = 8'hAA;
      dbuf[1] = 8'hBB;
      txn_write(8'hFF, 2);
      check("t2_wr_count", wr_count, 3);
      check("t2_wr_addr", last_wr_addr, 8'h00);
      check("t2_wr_data", last_wr_data, 8'hBB);
      check("t2_rd_addr", bus.rd_addr, 8'h01);

      // 42/3A, Sr, 43, read 0x04, NACK
      txn_read(1'b1, 8'h3A, 1);
      check("t3_rd_byte", first_rd, 8'h04);
      check("t3_rd_addr", bus.rd_addr, 8'h3A);
      check("t3_wr_count", wr_count, 3);

      // foreign address 0x60
      txn_foreign(8'h60, 2);
      check("t4_wr_count", wr_count, 3);

      // STOP after 4 data bits
      bus_start();
      write_byte(8'h42, a); check("t5_ack_dev", a, 1'b0);
      write_byte(8'h10, a); check("t5_ack_sub", a, 1'b0);
      exp_rd = 8'h10;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      finish_txn();
      check("t5_wr_count", wr_count, 3);

      // reset pulse while the target drives ACK
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(1'((8'h42 >> i) & 8'h01));
      m_sda = 1'b1; wait_clk(Q);
      m_scl = 1'b1; wait_clk(2);
      check("t6_ack_driven", bus.sda_oe, 1'b1);
      reset = 1'b1; wait_clk(1);
      reset = 1'b0;
      check("t6_oe_after_reset", bus.sda_oe, 1'b0);
      check("t6_busy_after_reset", bus.busy, 1'b0);
      model_reset();
      wait_clk(Q);
      m_scl = 1'b0; wait_clk(Q);
      bus_stop();
      wait_clk(4);
      check("t6_wr_count", wr_count, 3);

      // 42/12/80 after the reset
      dbuf[0] = 8'h80;
      txn_write(8'h12, 1);
      check("t7_wr_count", wr_count, 4);
      check("t7_wr_addr", last_wr_addr, 8'h12);
      check("t7_wr_data", last_wr_data, 8'h80);

      for (int t = 0; t < 25; t++) begin
         kind = $urandom_range(0, 3);
         sub  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) sub = 8'hFD;
         case (kind)
            0: begin
               n = $urandom_range(1, 4);
               for (int unsigned i = 0; i < n; i++) dbuf[i] = 8'($urandom);
               txn_write(sub, n);
            end
            1: txn_read(1'b1, sub, $urandom_range(1, 3));
            2: txn_read(1'b0, 8'h00, $urandom_range(1, 3));
            default: begin
               fa = 7'($urandom);
               if (fa == 7'h21) fa = 7'h30;
               txn_foreign({fa, 1'($urandom)}, 2);
            end
         endcase
      end

      wait_clk(10);
      check("final_wr_q_drained", wr_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
